lp805x_prescgen: RTL

- Prescaler tick generator; consumes the 3-bit prescaler select produced by the frequency scheduler.
- Generates a one-cycle clock-enable pulse every 2^(7-index) enabled cycles.
- Also generates a toggling divided-clock output for peripherals (timers, UART baud logic) in the lp805x core.
- Index changes are deferred to a period boundary so no tick period is truncated or stretched mid-count.

---
 rtl/lp805x_prescgen_if.sv | 34 +++
 rtl/lp805x_prescgen.sv | 133 +++++++++++++
 2 files changed

// File: rtl/lp805x_prescgen_if.sv
// Bus bundle between the frequency scheduler (master) and the prescaler
// tick generator (slave): index request handshake plus tick/divided-clock outputs.
interface lp805x_prescgen_if;
    logic       enable;
    logic [2:0] index;
    logic       update;
    logic       tick;
    logic       div_out;
    logic [2:0] cur_index;
    logic       pending;
    logic       ack;

    modport master (
        output enable,
        output index,
        output update,
        input  tick,
        input  div_out,
        input  cur_index,
        input  pending,
        input  ack
    );

    modport slave (
        input  enable,
        input  index,
        input  update,
        output tick,
        output div_out,
        output cur_index,
        output pending,
        output ack
    );
endinterface

// File: rtl/lp805x_prescgen.sv
// Prescaler tick generator: one-cycle tick every 2^(7-index) enabled cycles plus a
// toggling divided clock; index changes are deferred to the next period boundary.
module lp805x_prescgen #(
    parameter int CNT_W = 7
) (
    input  logic                clk,
    input  logic                rst,
    lp805x_prescgen_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W:0]   PER_ONE  = {{CNT_W{1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             div_out_q, div_out_d;
    logic [2:0]       cur_index_q, cur_index_d;
    logic             pending_q, pending_d;
    logic [2:0]       pend_idx_q, pend_idx_d;
    logic             ack_q, ack_d;

    state_t           state_s;
    logic [CNT_W:0]   period_s;
    logic [CNT_W:0]   period_m1_s;
    logic             term_s;

    // One extra bit keeps P=128 representable before taking P-1 in CNT_W bits.
    assign period_s    = PER_ONE << (3'd7 - cur_index_q);
    assign period_m1_s = period_s - PER_ONE;
    assign term_s      = (cnt_q == period_m1_s[CNT_W-1:0]);

    // Operating mode decoded from enable and the pending-request flag.
    always_comb begin
        state_s = ST_IDLE;
        if (!bus.enable) begin
            state_s = ST_IDLE;
        end else if (pending_q) begin
            state_s = ST_SWITCH;
        end else begin
            state_s = ST_RUN;
        end
    end

    // Next-state logic for counter, tick, divided clock and index handshake.
    always_comb begin
        cnt_d       = cnt_q;
        tick_d      = 1'b0;
        div_out_d   = div_out_q;
        cur_index_d = cur_index_q;
        pending_d   = pending_q;
        pend_idx_d  = pend_idx_q;
        ack_d       = 1'b0;
        case (state_s)
            ST_IDLE: begin
                // No period in flight that could be truncated, so apply at once.
                if (bus.update) begin
                    cur_index_d = bus.index;
                    cnt_d       = CNT_ZERO;
                    pending_d   = 1'b0;
                    ack_d       = 1'b1;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_RUN, ST_SWITCH: begin
                if (term_s) begin
                    cnt_d     = CNT_ZERO;
                    tick_d    = 1'b1;
                    div_out_d = ~div_out_q;
                    if (bus.update) begin
                        cur_index_d = bus.index;
                        pending_d   = 1'b0;
                        ack_d       = 1'b1;
                    end else if (state_s == ST_SWITCH) begin
                        cur_index_d = pend_idx_q;
                        pending_d   = 1'b0;
                        ack_d       = 1'b1;
                    end else begin
                        cur_index_d = cur_index_q;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    // Last request wins; it is held until the period boundary.
                    if (bus.update) begin
                        pend_idx_d = bus.index;
                        pending_d  = 1'b1;
                    end else begin
                        pend_idx_d = pend_idx_q;
                    end
                end
            end
            default: begin
                cnt_d     = CNT_ZERO;
                pending_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset taking priority over all inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= CNT_ZERO;
            tick_q      <= 1'b0;
            div_out_q   <= 1'b0;
            cur_index_q <= 3'd0;
            pending_q   <= 1'b0;
            pend_idx_q  <= 3'd0;
            ack_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            tick_q      <= tick_d;
            div_out_q   <= div_out_d;
            cur_index_q <= cur_index_d;
            pending_q   <= pending_d;
            pend_idx_q  <= pend_idx_d;
            ack_q       <= ack_d;
        end
    end

    assign bus.tick      = tick_q;
    assign bus.div_out   = div_out_q;
    assign bus.cur_index = cur_index_q;
    assign bus.pending   = pending_q;
    assign bus.ack       = ack_q;

endmodule
